uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter OVS_DIV, default 651, meaning sysclk cycles per 1/16-bit oversample tick (100 MHz at 9600 baud).
REQ-002 SHALL have parameter DEPTH, default 4, meaning FIFO entries; only powers of two from 2 to 16 are legal.
REQ-003 SHALL have one clock and an asynchronous active-high reset.
REQ-004 sysclk  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rxd  in  1  serial line, 8N1, LSB first, idle high, asynchronous to sysclk.
REQ-007 rd  in  1  pop request, one byte per asserted cycle.
REQ-008 err_clr  in  1  clears the sticky error flags.
REQ-009 rdata  out  8  head-of-FIFO byte (show-ahead).
REQ-010 rx_valid  out  1  FIFO non-empty.
REQ-011 rx_count  out  $clog2(DEPTH)+1  current occupancy.
REQ-012 frame_err  out  1  sticky flag: a stop bit was sampled low.
REQ-013 overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-014 irq  out  1  interrupt request to the peripheral block.

Function
REQ-015 SHALL pass rxd through a two-flop synchronizer whose flops reset to 1; "line" below means the synchronized value.
REQ-016 SHALL generate a one-cycle tick every OVS_DIV sysclk cycles from a counter that runs 0..OVS_DIV-1; the counter is cleared when IDLE detects line=0.
REQ-017 SHALL implement the states IDLE, START, DATA, STOP and BREAK, with a 4-bit per-bit tick counter (sc) and a 3-bit bit index.
REQ-018 IDLE: on line=0, go to START with sc=0.
REQ-019 START: on the 8th tick (mid-bit), go to DATA with sc=0 if line=0, otherwise return to IDLE (glitch rejection, no flags set).
REQ-020 DATA: sample line on every 16th tick into the shift register, LSB first; after bit index 7 is sampled, go to STOP.
REQ-021 STOP: on the 16th tick, if line=1, push the byte and go to IDLE; if line=0, discard the byte, set frame_err and go to BREAK.
REQ-022 BREAK: stay until line=1, then go to IDLE.
REQ-023 The push SHALL occur on the stop-sample cycle; the byte is visible on rdata and rx_valid one cycle later.
REQ-024 rd with rx_valid=1 SHALL pop the head entry; rd with the FIFO empty SHALL be ignored, with no underflow and no count change.
REQ-025 Push and pop in the same cycle SHALL both take effect and leave rx_count unchanged, including when the FIFO is full (no overrun).
REQ-026 A push to a full FIFO without a pop SHALL drop the new byte, set overrun, and leave the FIFO contents unchanged.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; rx_count SHALL saturate neither below 0 nor above DEPTH.
REQ-028 err_clr SHALL clear frame_err and overrun; if a set event occurs in the same cycle, the set SHALL win.
REQ-029 irq SHALL equal rx_valid OR frame_err OR overrun, registered, with one cycle latency.
REQ-030 rdata SHALL be 8'h00 when the FIFO is empty.

Reset
REQ-031 While reset=1, the block SHALL be in IDLE with all counters and pointers 0, synchronizer flops 1, rx_count=0, rx_valid=0, rdata=8'h00, frame_err=0, overrun=0 and irq=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame and leave no partial byte in the FIFO.
REQ-033 After reset release, a frame whose start bit is already in progress SHALL be treated as glitch or frame error only; the block SHALL NOT hang.

Verification (OVS_DIV=4, so 64 sysclk cycles per bit)
REQ-034 Send 8'hA5 as a valid frame -> one cycle after the stop sample: rx_valid=1, rdata=8'hA5, rx_count=1; then rd for 1 cycle -> rx_valid=0, rdata=8'h00.
REQ-035 Send 5 bytes 8'h01..8'h05 with no reads (DEPTH=4) -> rx_count=4, overrun=1, successive pops return 01,02,03,04; then err_clr -> overrun=0, irq=0.
REQ-036 Hold rxd low for 16 sysclk cycles, then high -> state returns to IDLE, rx_count=0, no flags set.
REQ-037 Send 8'h3C with the stop bit low and hold low for 200 cycles -> frame_err=1, irq=1, rx_count=0; the block stays in BREAK until rxd goes high, and a following 8'h55 frame is received correctly.
REQ-038 FIFO full (4 entries) and rd asserted on the push cycle of 8'h77 -> rx_count stays 4, overrun=0, 8'h77 is the last byte popped.
REQ-039 Assert reset during DATA bit 3 of a frame -> all outputs at reset values; after release a new 8'h0F frame is received as 8'h0F.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a show-ahead receive FIFO.
// Ports:
//   sysclk    - clock, all state changes on the rising edge
//   reset     - asynchronous active-high reset
//   rxd       - serial input, idle high, LSB first, asynchronous to sysclk
//   rd        - pop one byte per asserted cycle (ignored when empty)
//   err_clr   - clears the sticky frame_err / overrun flags
//   rdata     - head-of-FIFO byte, 8'h00 when empty
//   rx_valid  - FIFO non-empty
//   rx_count  - FIFO occupancy
//   frame_err - sticky: a stop bit was sampled low
//   overrun   - sticky: a received byte was dropped because the FIFO was full
//   irq       - registered OR of rx_valid, frame_err and overrun
module uart_rx_fifo #(
  parameter int unsigned OVS_DIV = 651,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     rxd,
  input  logic                     rd,
  input  logic                     err_clr,
  output logic [7:0]               rdata,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     frame_err,
  output logic                     overrun,
  output logic                     irq
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned DIVW = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic            sync1, line;
  logic [DIVW-1:0] div_cnt;
  logic            tick_c;
  state_t          state, state_n;
  logic [3:0]      sc, sc_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            push_c, ferr_set_c, div_clr_c;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0]   count_n;
  logic            pop_ok_c, full_c, push_ok_c, ovr_set_c;
  logic [7:0]      head_n;

  // Two-flop synchronizer, idle-high reset value
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= rxd;
      line  <= sync1;
    end
  end

  // Oversample tick divider, realigned to the start-bit falling edge
  assign tick_c = (div_cnt == DIVW'(OVS_DIV - 1));

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                  div_cnt <= '0;
    else if (div_clr_c || tick_c) div_cnt <= '0;
    else                        div_cnt <= div_cnt + DIVW'(1);
  end

  // Receiver state register
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sc      <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      sc      <= sc_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
    end
  end

  // Receiver next-state logic
  always_comb begin
    state_n    = state;
    sc_n       = sc;
    bit_n      = bit_idx;
    shreg_n    = shreg;
    push_c     = 1'b0;
    ferr_set_c = 1'b0;
    div_clr_c  = 1'b0;
    case (state)
      IDLE: begin
        if (!line) begin
          state_n   = START;
          sc_n      = '0;
          bit_n     = '0;
          div_clr_c = 1'b1;
        end
      end
      START: begin
        if (tick_c) begin
          if (sc == 4'd7) begin
            sc_n    = '0;
            // Line back high at mid start bit means a glitch
            state_n = line ? IDLE : DATA;
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          if (sc == 4'd15) begin
            sc_n    = '0;
            shreg_n = {line, shreg[7:1]};
            bit_n   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) state_n = STOP;
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          if (sc == 4'd15) begin
            sc_n = '0;
            if (line) begin
              push_c  = 1'b1;
              state_n = IDLE;
            end else begin
              ferr_set_c = 1'b1;
              state_n    = BREAK;
            end
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      BREAK: begin
        if (line) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO control; a pop frees the slot for a simultaneous push even when full
  assign pop_ok_c  = rd && (rx_count != '0);
  assign full_c    = (rx_count == CW'(DEPTH));
  assign push_ok_c = push_c && (!full_c || pop_ok_c);
  assign ovr_set_c = push_c && full_c && !pop_ok_c;
  assign wr_ptr_n  = push_ok_c ? wr_ptr + AW'(1) : wr_ptr;
  assign rd_ptr_n  = pop_ok_c  ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_n = rx_count;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_n = rx_count + CW'(1);
      2'b01:   count_n = rx_count - CW'(1);
      default: count_n = rx_count;
    endcase
  end

  // Next head byte: the incoming byte when it lands at the new read slot
  always_comb begin
    head_n = 8'h00;
    if (count_n != '0) begin
      if (push_ok_c && (wr_ptr == rd_ptr_n)) head_n = shreg;
      else                                   head_n = mem[rd_ptr_n];
    end
  end

  // Storage array
  always_ff @(posedge sysclk) begin
    if (push_ok_c) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, registered outputs and sticky flags (set beats clear)
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rx_count  <= '0;
      rx_valid  <= 1'b0;
      rdata     <= 8'h00;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      rx_count  <= count_n;
      rx_valid  <= (count_n != '0);
      rdata     <= head_n;
      frame_err <= ferr_set_c ? 1'b1 : (err_clr ? 1'b0 : frame_err);
      overrun   <= ovr_set_c  ? 1'b1 : (err_clr ? 1'b0 : overrun);
      irq       <= rx_valid | frame_err | overrun;
    end
  end

endmodule
